// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multi-cycle control FSM for the 32-bit datapath.
// Each instruction goes through FETCH, DECODE, EXEC and, for register
// writing ops, WB. The FSM handshakes with instruction memory and drives
// the datapath control lines.
// Optional performance counters are built only when PERF_CNT_EN is defined.
module multicycle_sequencer #(
   parameter int FETCH_TIMEOUT = 15
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       start,
   input  logic       imem_ack,
   input  logic [4:0] opcode,
   input  logic       branch_taken,
   output logic       imem_req,
   output logic       ir_load,
   output logic       pc_write,
   output logic       pc_src,
   output logic       offset_sel,
   output logic [3:0] alu_op,
   output logic       reg_write,
   output logic       wreg_sel,
   output logic       wdata_sel,
   output logic       aluB_sel,
   output logic [2:0] state,
   output logic       halted,
   output logic       illegal
`ifdef PERF_CNT_EN
   ,
   output logic [31:0] cycle_count,
   output logic [31:0] instr_retired
`endif
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;
   localparam logic [2:0] S_ERROR  = 3'd6;

   localparam logic [4:0] OP_AR   = 5'b00000;
   localparam logic [4:0] OP_T    = 5'b00001;
   localparam logic [4:0] OP_I    = 5'b00010;
   localparam logic [4:0] OP_J    = 5'b00011;
   localparam logic [4:0] OP_M    = 5'b00100;
   localparam logic [4:0] OP_HALT = 5'b11111;

   localparam logic [7:0] TIMEOUT_C = FETCH_TIMEOUT[7:0];

   logic [2:0] state_q, state_d;
   logic [4:0] op_q, op_d;
   logic [7:0] wait_q, wait_d;

   // Next-state logic: fetch handshake with timeout, decode dispatch, execute/writeback sequencing.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      wait_d  = wait_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (imem_ack) begin
               op_d    = opcode;
               wait_d  = 8'd0;
               state_d = S_DECODE;
            end else if (wait_q == TIMEOUT_C) begin
               wait_d  = 8'd0;
               state_d = S_ERROR;
            end else begin
               wait_d = 8'(wait_q + 8'd1);
            end
         end
         S_DECODE: begin
            case (op_q)
               OP_AR, OP_T, OP_I, OP_J, OP_M: state_d = S_EXEC;
               OP_HALT:                       state_d = S_HALT;
               default:                       state_d = S_ERROR;
            endcase
         end
         S_EXEC: begin
            if (op_q == OP_J || op_q == OP_M) state_d = S_FETCH;
            else                              state_d = S_WB;
         end
         S_WB:    state_d = S_FETCH;
         S_HALT:  state_d = S_HALT;
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_IDLE;
      endcase
   end

   // State, latched opcode and fetch wait counter; reset aborts any instruction in flight.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= S_IDLE;
         op_q    <= 5'd0;
         wait_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         wait_q  <= wait_d;
      end
   end

   // Moore control decode from state and op_q; only ir_load and the M-branch pc_src follow live inputs.
   always_comb begin
      imem_req   = 1'b0;
      ir_load    = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      offset_sel = 1'b0;
      alu_op     = 4'b0000;
      reg_write  = 1'b0;
      wreg_sel   = 1'b0;
      wdata_sel  = 1'b0;
      aluB_sel   = 1'b0;
      if (state_q == S_FETCH) begin
         imem_req = 1'b1;
         ir_load  = imem_ack;
      end
      if (state_q == S_EXEC || state_q == S_WB) begin
         case (op_q)
            OP_AR: begin
               alu_op   = 4'b0000;
               aluB_sel = 1'b0;
            end
            OP_T: begin
               wdata_sel = 1'b1;
               wreg_sel  = 1'b1;
            end
            OP_I: begin
               alu_op   = 4'b0001;
               aluB_sel = 1'b1;
            end
            OP_M: begin
               alu_op     = 4'b0010;
               offset_sel = 1'b1;
            end
            default: ;
         endcase
      end
      if (state_q == S_EXEC) begin
         if (op_q == OP_J) begin
            pc_write   = 1'b1;
            pc_src     = 1'b1;
            offset_sel = 1'b0;
         end else if (op_q == OP_M) begin
            pc_write = 1'b1;
            pc_src   = branch_taken;
         end
      end
      if (state_q == S_WB) begin
         reg_write = 1'b1;
         pc_write  = 1'b1;
         pc_src    = 1'b0;
      end
   end

   assign state   = state_q;
   assign halted  = (state_q == S_HALT);
   assign illegal = (state_q == S_ERROR);

`ifdef PERF_CNT_EN
   logic [31:0] cycle_count_q;
   logic [31:0] instr_retired_q;
   logic        busy;
   logic        retire;

   assign busy   = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                   (state_q == S_EXEC)  || (state_q == S_WB);
   assign retire = (state_d == S_FETCH) && ((state_q == S_EXEC) || (state_q == S_WB));

   // Saturating counters for active cycles and completed instructions.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         cycle_count_q   <= 32'd0;
         instr_retired_q <= 32'd0;
      end else begin
         if (busy && cycle_count_q != 32'hFFFF_FFFF)
            cycle_count_q <= cycle_count_q + 32'd1;
         if (retire && instr_retired_q != 32'hFFFF_FFFF)
            instr_retired_q <= instr_retired_q + 32'd1;
      end
   end

   assign cycle_count   = cycle_count_q;
   assign instr_retired = instr_retired_q;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Testbench for multicycle_sequencer: table of per-cycle vectors for the
// main instruction flow plus hand sequences for timeout, illegal opcode
// and asynchronous reset corner cases.
module tb_multicycle_sequencer;

   logic       clock;
   logic       RESET;
   logic       start;
   logic       imemAck;
   logic [4:0] opcode;
   logic       branchTaken;
   logic       imemReq, irLoad, pcWrite, pcSrc, offsetSel;
   logic [3:0] aluOp;
   logic       regWrite, wregSel, wdataSel, aluBSel;
   logic [2:0] stateOut;
   logic       halted, illegal;
`ifdef PERF_CNT_EN
   logic [31:0] cycleCount, instrRetired;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        st;
      logic        ack;
      logic [4:0]  opc;
      logic        br;
      logic [17:0] exp;
   } vec_t;

   vec_t vecs[26];

   multicycle_sequencer #(.FETCH_TIMEOUT(15)) dut (
      .CLK(clock),
      .RESET(RESET),
      .start(start),
      .imem_ack(imemAck),
      .opcode(opcode),
      .branch_taken(branchTaken),
      .imem_req(imemReq),
      .ir_load(irLoad),
      .pc_write(pcWrite),
      .pc_src(pcSrc),
      .offset_sel(offsetSel),
      .alu_op(aluOp),
      .reg_write(regWrite),
      .wreg_sel(wregSel),
      .wdata_sel(wdataSel),
      .aluB_sel(aluBSel),
      .state(stateOut),
      .halted(halted),
      .illegal(illegal)
`ifdef PERF_CNT_EN
      ,
      .cycle_count(cycleCount),
      .instr_retired(instrRetired)
`endif
   );

   // Free-running clock, 10 time units per period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Packs an expected output set in the same order checkOutput uses.
   function automatic logic [17:0] pk(input logic [2:0] st, input logic req, input logic irl,
                                      input logic pcw, input logic pcs, input logic ofs,
                                      input logic [3:0] alu, input logic rw, input logic wrs,
                                      input logic wds, input logic bs, input logic h,
                                      input logic il);
      return {st, req, irl, pcw, pcs, ofs, alu, rw, wrs, wds, bs, h, il};
   endfunction

   function automatic vec_t mkVec(input logic st, input logic ack, input logic [4:0] opc,
                                  input logic br, input logic [17:0] e);
      vec_t v;
      v.st = st; v.ack = ack; v.opc = opc; v.br = br; v.exp = e;
      return v;
   endfunction

   task automatic applyStimulus(input logic st, input logic ack, input logic [4:0] opc,
                                input logic br);
      start       = st;
      imemAck     = ack;
      opcode      = opc;
      branchTaken = br;
   endtask

   task automatic checkOutput(input string name, input logic [17:0] exp);
      logic [17:0] act;
      act = {stateOut, imemReq, irLoad, pcWrite, pcSrc, offsetSel, aluOp,
             regWrite, wregSel, wdataSel, aluBSel, halted, illegal};
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Assert reset away from the clock edge, confirm outputs clear, then release.
   task automatic doReset(input string name);
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
      #2;
      RESET = 1'b0;
      #1;
      checkOutput(name, pk(3'd0, 0,0,0,0,0, 4'd0, 0,0,0,0, 0,0));
      tick();
      RESET = 1'b1;
   endtask

   // Starts from IDLE and holds ack low for n FETCH cycles, checking FETCH each cycle.
   task automatic startAndWait(input string name, input int n);
      applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
      for (int k = 0; k < n; k++) begin
         #1;
         checkOutput($sformatf("%s_wait%0d", name, k), pk(3'd1, 1,0,0,0,0, 4'd0, 0,0,0,0, 0,0));
         tick();
      end
   endtask

   initial begin
      RESET = 1'b0;
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);

      vecs[0]  = mkVec(1, 0, 5'b00000, 0, pk(3'd0, 0,0,0,0,0, 4'd0, 0,0,0,0, 0,0));
      vecs[1]  = mkVec(0, 1, 5'b00000, 0, pk(3'd1, 1,1,0,0,0, 4'd0, 0,0,0,0, 0,0));
      vecs[2]  = mkVec(0, 0, 5'b00000, 0, pk(3'd2, 0,0,0,0,0, 4'd0, 0,0,0,0, 0,0));
      vecs[3]  = mkVec(0, 0, 5'b00000, 0, pk(3'd3, 0,0,0,0,0, 4'd0, 0,0,0,0, 0,0));
      vecs[4]  = mkVec(0, 0, 5'b00000, 0, pk(3'd4, 0,0,1,0,0, 4'd0, 1,0,0,0, 0,0));
      vecs[5]  = mkVec(0, 1, 5'b00011, 0, pk(3'd1, 1,1,0,0,0, 4'd0, 0,0,0,0, 0,0));
      vecs[6]  = mkVec(0, 0, 5'b00000, 0, pk(3'd2, 0,0,0,0,0, 4'd0, 0,0,0,0, 0,0));
      vecs[7]  = mkVec(0, 0, 5'b00000, 0, pk(3'd3, 0,0,1,1,0, 4'd0, 0,0,0,0, 0,0));
      vecs[8]  = mkVec(0, 1, 5'b00100, 0, pk(3'd1, 1,1,0,0,0, 4'd0, 0,0,0,0, 0,0));
      vecs[9]  = mkVec(0, 0, 5'b00000, 0, pk(3'd2, 0,0,0,0,0, 4'd0, 0,0,0,0, 0,0));
      vecs[10] = mkVec(0, 0, 5'b00000, 1, pk(3'd3, 0,0,1,1,1, 4'd2, 0,0,0,0, 0,0));
      vecs[11] = mkVec(0, 1, 5'b00100, 0, pk(3'd1, 1,1,0,0,0, 4'd0, 0,0,0,0, 0,0));
      vecs[12] = mkVec(0, 0, 5'b00000, 0, pk(3'd2, 0,0,0,0,0, 4'd0, 0,0,0,0, 0,0));
      vecs[13] = mkVec(0, 0, 5'b00000, 0, pk(3'd3, 0,0,1,0,1, 4'd2, 0,0,0,0, 0,0));
      vecs[14] = mkVec(0, 1, 5'b00001, 0, pk(3'd1, 1,1,0,0,0, 4'd0, 0,0,0,0, 0,0));
      vecs[15] = mkVec(1, 1, 5'b11111, 0, pk(3'd2, 0,0,0,0,0, 4'd0, 0,0,0,0, 0,0));
      vecs[16] = mkVec(0, 0, 5'b00000, 0, pk(3'd3, 0,0,0,0,0, 4'd0, 0,1,1,0, 0,0));
      vecs[17] = mkVec(0, 0, 5'b00000, 0, pk(3'd4, 0,0,1,0,0, 4'd0, 1,1,1,0, 0,0));
      vecs[18] = mkVec(0, 1, 5'b00010, 0, pk(3'd1, 1,1,0,0,0, 4'd0, 0,0,0,0, 0,0));
      vecs[19] = mkVec(0, 0, 5'b00000, 0, pk(3'd2, 0,0,0,0,0, 4'd0, 0,0,0,0, 0,0));
      vecs[20] = mkVec(0, 0, 5'b00000, 0, pk(3'd3, 0,0,0,0,0, 4'd1, 0,0,0,1, 0,0));
      vecs[21] = mkVec(0, 0, 5'b00000, 0, pk(3'd4, 0,0,1,0,0, 4'd1, 1,0,0,1, 0,0));
      vecs[22] = mkVec(0, 1, 5'b11111, 0, pk(3'd1, 1,1,0,0,0, 4'd0, 0,0,0,0, 0,0));
      vecs[23] = mkVec(0, 0, 5'b00000, 0, pk(3'd2, 0,0,0,0,0, 4'd0, 0,0,0,0, 0,0));
      vecs[24] = mkVec(1, 1, 5'b00000, 1, pk(3'd5, 0,0,0,0,0, 4'd0, 0,0,0,0, 1,0));
      vecs[25] = mkVec(1, 1, 5'b00000, 1, pk(3'd5, 0,0,0,0,0, 4'd0, 0,0,0,0, 1,0));

      // Main flow: AR, J, M taken, M not taken, T (with ignored start/ack in DECODE), I, HALT.
      doReset("reset_initial");
      tick();
      for (int i = 0; i < 26; i++) begin
         applyStimulus(vecs[i].st, vecs[i].ack, vecs[i].opc, vecs[i].br);
         #1;
         checkOutput($sformatf("vec%0d", i), vecs[i].exp);
`ifdef PERF_CNT_EN
         if (i == 5) begin
            checkValue("perf_cycles_after_ar", cycleCount, 32'd4);
            checkValue("perf_retired_after_ar", instrRetired, 32'd1);
         end
         if (i == 8) begin
            checkValue("perf_cycles_after_j", cycleCount, 32'd7);
            checkValue("perf_retired_after_j", instrRetired, 32'd2);
         end
`endif
         tick();
      end

      // Reset leaves HALT.
      doReset("reset_from_halt");

      // Ack never arrives: 16 FETCH cycles (wait count 0..15), then ERROR.
      tick();
      startAndWait("timeout", 16);
      #1;
      checkOutput("timeout_error", pk(3'd6, 0,0,0,0,0, 4'd0, 0,0,0,0, 0,1));
      applyStimulus(1'b1, 1'b1, 5'b00000, 1'b0);
      tick();
      checkOutput("error_sticky", pk(3'd6, 0,0,0,0,0, 4'd0, 0,0,0,0, 0,1));

      // Ack arrives exactly when the wait count reaches the limit: ack wins.
      doReset("reset_from_error");
      tick();
      startAndWait("ackAtLimit", 15);
      applyStimulus(1'b0, 1'b1, 5'b00000, 1'b0);
      #1;
      checkOutput("ackAtLimit_fetch", pk(3'd1, 1,1,0,0,0, 4'd0, 0,0,0,0, 0,0));
      tick();
      applyStimulus(1'b0, 1'b0, 5'b00000, 1'b0);
      checkOutput("ackAtLimit_decode", pk(3'd2, 0,0,0,0,0, 4'd0, 0,0,0,0, 0,0));
      tick();
      tick();
      tick();
      checkOutput("ackAtLimit_refetch", pk(3'd1, 1,0,0,0,0, 4'd0, 0,0,0,0, 0,0));

      // Illegal opcode goes to ERROR out of DECODE.
      applyStimulus(1'b0, 1'b1, 5'b01010, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 5'b00000, 1'b0);
      checkOutput("illegal_decode", pk(3'd2, 0,0,0,0,0, 4'd0, 0,0,0,0, 0,0));
      tick();
      checkOutput("illegal_error", pk(3'd6, 0,0,0,0,0, 4'd0, 0,0,0,0, 0,1));

      // Reset in the middle of an I writeback.
      doReset("reset_before_i");
      tick();
      applyStimulus(1'b1, 1'b0, 5'b00000, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b1, 5'b00010, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 5'b00000, 1'b0);
      tick();
      tick();
      checkOutput("midwb_wb", pk(3'd4, 0,0,1,0,0, 4'd1, 1,0,0,1, 0,0));
      #2;
      RESET = 1'b0;
      #1;
      checkOutput("midwb_async_clear", pk(3'd0, 0,0,0,0,0, 4'd0, 0,0,0,0, 0,0));
      tick();
      checkOutput("midwb_edge_no_write", pk(3'd0, 0,0,0,0,0, 4'd0, 0,0,0,0, 0,0));
      RESET = 1'b1;
      tick();
      startAndWait("refetch", 15);
      applyStimulus(1'b0, 1'b1, 5'b00000, 1'b0);
      #1;
      checkOutput("refetch_ack", pk(3'd1, 1,1,0,0,0, 4'd0, 0,0,0,0, 0,0));
      tick();
      applyStimulus(1'b0, 1'b0, 5'b00000, 1'b0);
      checkOutput("refetch_decode", pk(3'd2, 0,0,0,0,0, 4'd0, 0,0,0,0, 0,0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
